muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_seq_pkg.sv | 15 +
 rtl/muldiv_seq.sv | 109 ++++++++++
 tb/tb_muldiv_seq.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_pkg.sv
// Shared constants for the iterative multiply/divide sequencer:
// state encodings, the default iteration count and the counter width.
package muldiv_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int ITER_DEF = 32;
  localparam int CNT_W    = 5;

endpackage

// File: rtl/muldiv_seq.sv
// Control sequencer for a multi-cycle MULT/DIV unit: issues load/step/fix/write
// strobes to the datapath and generates the pipeline stalls around it.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int ITER = ITER_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult_ex_i,
  input  logic             start_div_ex_i,
  input  logic             signed_ex_i,
  input  logic             rd_hilo_iss_i,
  input  logic             abort_i,
  output logic             load_o,
  output logic             step_o,
  output logic             fix_o,
  output logic             hilo_we_o,
  output logic             is_div_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             stall_fetch_o,
  output logic             stall_iss_o,
  output logic             stall_ex_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             is_div_q, sgn_q;
  logic             start, load, step, fix, hilo_we;

  assign start = start_mult_ex_i | start_div_ex_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sgn_q    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      if (load) begin
        // divide wins when both starts are present
        is_div_q <= start_div_ex_i;
        sgn_q    <= signed_ex_i;
      end
    end
  end

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    load      = 1'b0;
    step      = 1'b0;
    fix       = 1'b0;
    hilo_we   = 1'b0;
    case (state_q)
      IDLE: if (start && !reset) begin
        load      = 1'b1;
        cnt_nxt   = '0;
        state_nxt = RUN;
      end
      RUN: begin
        step = 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = sgn_q ? FIX : DONE;
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end
      FIX: begin
        fix       = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        hilo_we   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // a kill squashes every datapath strobe this cycle, including a new load
    if (abort_i) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      load      = 1'b0;
      step      = 1'b0;
      fix       = 1'b0;
      hilo_we   = 1'b0;
    end
  end

  assign load_o    = load;
  assign step_o    = step;
  assign fix_o     = fix;
  assign hilo_we_o = hilo_we;
  assign is_div_o  = is_div_q;
  assign busy_o    = (state_q != IDLE);
  assign cnt_o     = cnt_q;

  // HI/LO readers wait for any pending result; a new op waits for the unit
  assign stall_ex_o    = start & busy_o;
  assign stall_fetch_o = (rd_hilo_iss_i & (busy_o | load)) | stall_ex_o;
  assign stall_iss_o   = stall_fetch_o;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: an IDLE-decode vector table plus cycle
// timelines for multiply, signed, hazard, structural, abort and reset cases.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start_mult_ex_i = 1'b0, start_div_ex_i = 1'b0, signed_ex_i = 1'b0;
  logic             rd_hilo_iss_i = 1'b0, abort_i = 1'b0;
  logic             load_o, step_o, fix_o, hilo_we_o, is_div_o, busy_o;
  logic [CNT_W-1:0] cnt_o;
  logic             stall_fetch_o, stall_iss_o, stall_ex_o;

  int checks = 0;
  int errors = 0;

  muldiv_seq #(.ITER(32)) dut (
    .clk(clk), .reset(reset),
    .start_mult_ex_i(start_mult_ex_i), .start_div_ex_i(start_div_ex_i),
    .signed_ex_i(signed_ex_i), .rd_hilo_iss_i(rd_hilo_iss_i), .abort_i(abort_i),
    .load_o(load_o), .step_o(step_o), .fix_o(fix_o), .hilo_we_o(hilo_we_o),
    .is_div_o(is_div_o), .busy_o(busy_o), .cnt_o(cnt_o),
    .stall_fetch_o(stall_fetch_o), .stall_iss_o(stall_iss_o), .stall_ex_o(stall_ex_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic mult, div, sgn, rd, abort;
    logic exp_load, exp_stall_fi, exp_stall_ex, exp_busy, exp_is_div;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    start_mult_ex_i = 1'b0; start_div_ex_i = 1'b0; signed_ex_i = 1'b0;
    rd_hilo_iss_i = 1'b0; abort_i = 1'b0;
  endtask

  task automatic do_reset();
    clear_in();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  // per-cycle control check against the expected timeline
  task automatic chk_ctl(input string tag, input int c, input bit el, input bit es,
                         input bit ef, input bit ew, input bit eb);
    chk($sformatf("%s load c%0d", tag, c), int'(load_o), int'(el));
    chk($sformatf("%s step c%0d", tag, c), int'(step_o), int'(es));
    chk($sformatf("%s fix c%0d", tag, c), int'(fix_o), int'(ef));
    chk($sformatf("%s hilo_we c%0d", tag, c), int'(hilo_we_o), int'(ew));
    chk($sformatf("%s busy c%0d", tag, c), int'(busy_o), int'(eb));
    chk($sformatf("%s onehot c%0d", tag, c),
        int'(load_o) + int'(step_o) + int'(fix_o) + int'(hilo_we_o) <= 1 ? 1 : 0, 1);
  endtask

  initial begin
    //          mult div sgn rd ab | load sfi sex busy isdiv
    vecs[0] = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0};
    vecs[1] = '{1, 0, 0, 0, 0,  1, 0, 0, 1, 0};
    vecs[2] = '{0, 1, 1, 0, 0,  1, 0, 0, 1, 1};
    vecs[3] = '{1, 1, 0, 0, 0,  1, 0, 0, 1, 1};
    vecs[4] = '{1, 0, 0, 0, 1,  0, 0, 0, 0, 0};
    vecs[5] = '{0, 0, 0, 1, 0,  0, 0, 0, 0, 0};
    vecs[6] = '{1, 0, 1, 1, 0,  1, 1, 0, 1, 0};
    vecs[7] = '{0, 1, 0, 1, 1,  0, 0, 0, 0, 0};
    vecs[8] = '{0, 1, 0, 1, 0,  1, 1, 0, 1, 1};

    // reset state, with a start request present during reset
    next_cycle();
    start_mult_ex_i = 1'b1; rd_hilo_iss_i = 1'b1;
    #1;
    chk("reset load", int'(load_o), 0);
    chk("reset busy", int'(busy_o), 0);
    chk("reset cnt", int'(cnt_o), 0);
    chk("reset is_div", int'(is_div_o), 0);
    chk("reset stall_fetch", int'(stall_fetch_o), 0);
    chk("reset stall_ex", int'(stall_ex_o), 0);

    // IDLE decode table
    for (int i = 0; i < 9; i++) begin
      do_reset();
      start_mult_ex_i = vecs[i].mult; start_div_ex_i = vecs[i].div;
      signed_ex_i = vecs[i].sgn; rd_hilo_iss_i = vecs[i].rd; abort_i = vecs[i].abort;
      #1;
      chk($sformatf("v%0d load", i), int'(load_o), int'(vecs[i].exp_load));
      chk($sformatf("v%0d stall_fetch", i), int'(stall_fetch_o), int'(vecs[i].exp_stall_fi));
      chk($sformatf("v%0d stall_iss", i), int'(stall_iss_o), int'(vecs[i].exp_stall_fi));
      chk($sformatf("v%0d stall_ex", i), int'(stall_ex_o), int'(vecs[i].exp_stall_ex));
      next_cycle();
      clear_in();
      #1;
      chk($sformatf("v%0d busy", i), int'(busy_o), int'(vecs[i].exp_busy));
      chk($sformatf("v%0d is_div", i), int'(is_div_o), int'(vecs[i].exp_is_div));
    end

    // A: MULTU timeline and counter
    do_reset();
    for (int c = 0; c <= 36; c++) begin
      start_mult_ex_i = (c == 0);
      #1;
      chk_ctl("A", c, c == 0, c >= 1 && c <= 32, 0, c == 33, c >= 1 && c <= 33);
      chk($sformatf("A cnt c%0d", c), int'(cnt_o), (c >= 1 && c <= 32) ? c - 1 : 0);
      next_cycle();
    end

    // B: signed MULT, MFLO in ISSUE from cycle 5 onward
    do_reset();
    for (int c = 0; c <= 37; c++) begin
      start_mult_ex_i = (c == 0); signed_ex_i = (c == 0); rd_hilo_iss_i = (c >= 5);
      #1;
      chk_ctl("B", c, c == 0, c >= 1 && c <= 32, c == 33, c == 34, c >= 1 && c <= 34);
      chk($sformatf("B stall_fetch c%0d", c), int'(stall_fetch_o), int'(c >= 5 && c <= 34));
      chk($sformatf("B stall_iss c%0d", c), int'(stall_iss_o), int'(c >= 5 && c <= 34));
      chk($sformatf("B stall_ex c%0d", c), int'(stall_ex_o), 0);
      next_cycle();
    end

    // C: signed DIV aborted at cycle 15
    do_reset();
    for (int c = 0; c <= 40; c++) begin
      start_div_ex_i = (c == 0); signed_ex_i = (c == 0); abort_i = (c == 15);
      #1;
      chk_ctl("C", c, c == 0, c >= 1 && c <= 14, 0, 0, c >= 1 && c <= 15);
      if (c == 16) chk("C cnt after abort", int'(cnt_o), 0);
      next_cycle();
    end

    // D: second MULTU waits in EX from cycle 10 until the unit is free
    do_reset();
    for (int c = 0; c <= 69; c++) begin
      start_mult_ex_i = (c == 0) || (c >= 10 && c <= 34);
      #1;
      chk_ctl("D", c, c == 0 || c == 34, (c >= 1 && c <= 32) || (c >= 35 && c <= 66), 0,
              c == 33 || c == 67, (c >= 1 && c <= 33) || (c >= 35 && c <= 67));
      chk($sformatf("D stall_ex c%0d", c), int'(stall_ex_o), int'(c >= 10 && c <= 33));
      chk($sformatf("D stall_fetch c%0d", c), int'(stall_fetch_o), int'(c >= 10 && c <= 33));
      chk($sformatf("D stall_iss c%0d", c), int'(stall_iss_o), int'(c >= 10 && c <= 33));
      next_cycle();
    end

    // E: reset pulse at cycle 20 of a MULT
    do_reset();
    for (int c = 0; c <= 40; c++) begin
      start_mult_ex_i = (c == 0) || (c == 20);
      rd_hilo_iss_i = (c == 20);
      reset = (c == 20);
      #1;
      if (c < 20) begin
        chk_ctl("E", c, c == 0, c >= 1, 0, 0, c >= 1);
      end else begin
        chk_ctl("E", c, 0, 0, 0, 0, 0);
        chk($sformatf("E cnt c%0d", c), int'(cnt_o), 0);
        chk($sformatf("E stall_fetch c%0d", c), int'(stall_fetch_o), 0);
      end
      next_cycle();
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
